// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation/state encodings and default width shared by mul_div_unit.
package muldiv_pkg;
    localparam int XLEN_DEF = 32;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration; mode_i=0 shift-add multiply, mode_i=1 restoring divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem;
    logic          ge;
    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        // Partial remainder is one bit wider than the divisor before the trial subtract.
        rem  = {hi_i, lo_i[XLEN-1]};
        ge   = rem >= {1'b0, b_i};
        hi_o = mode_i ? (ge ? rem[XLEN-1:0] - b_i : rem[XLEN-1:0]) : sum[XLEN:1];
        lo_o = mode_i ? {lo_i[XLEN-2:0], ge} : {sum[0], lo_i[XLEN-1:1]};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers for the MIPS EX stage.
// Define MULDIV_DIV_EN to build the divide datapath; without it divide starts are ignored.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [2*XLEN-1:0]        acc_q, acc_d, prod;
    logic [XLEN-1:0]          b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]          rs_abs, rt_abs, quo, rem;
    logic                     div_q, div_d, negp_q, negp_d, negr_q, negr_d;
    logic                     dz_q, dz_d, pend_q, pend_d, done_q, done_d;
    logic                     sgn, accept;
    logic [UNROLL:0][XLEN-1:0] hi_c, lo_c;

    // acc holds {hi, lo}: product for multiply, {remainder, quotient} for divide.
    assign hi_c[0] = acc_q[2*XLEN-1:XLEN];
    assign lo_c[0] = acc_q[XLEN-1:0];

    genvar g;
    generate
        for (g = 0; g < UNROLL; g++) begin : g_step
            muldiv_step #(.XLEN(XLEN)) u_step (
                .mode_i (div_q),
                .hi_i   (hi_c[g]),
                .lo_i   (lo_c[g]),
                .b_i    (b_q),
                .hi_o   (hi_c[g+1]),
                .lo_o   (lo_c[g+1])
            );
        end
    endgenerate

    always_comb begin
        sgn     = op_i == OP_MULT || op_i == OP_DIV;
        accept  = state_q == S_IDLE && start_i && !flush_i && (DIV_EN || !op_i[1]);
        rs_abs  = sgn && rs_i[XLEN-1] ? -rs_i : rs_i;
        rt_abs  = sgn && rt_i[XLEN-1] ? -rt_i : rt_i;
        prod    = negp_q ? -acc_q : acc_q;
        quo     = dz_q ? '1 : negp_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        b_d     = b_q;
        div_d   = div_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        pend_d  = 1'b0;
        done_d  = pend_q;
        // The fixed result waits one cycle in acc before landing in HI/LO.
        hi_d    = pend_q ? acc_q[2*XLEN-1:XLEN] : hi_q;
        lo_d    = pend_q ? acc_q[XLEN-1:0] : lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    count_d = CW'(N);
                    div_d   = DIV_EN && op_i[1];
                    acc_d   = {{XLEN{1'b0}}, op_i[1] ? rs_abs : rt_abs};
                    b_d     = op_i[1] ? rt_abs : rs_abs;
                    negp_d  = sgn && (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
                    negr_d  = sgn && rs_i[XLEN-1];
                    dz_d    = rt_i == '0;
                end else begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            S_CALC: begin
                acc_d   = {hi_c[UNROLL], lo_c[UNROLL]};
                count_d = count_q - 1'b1;
                state_d = flush_i ? S_IDLE : count_q == CW'(1) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                acc_d   = div_q ? {rem, quo} : prod;
                pend_d  = !flush_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            div_q   <= div_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = state_q != S_IDLE;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule
